// File: rtl/dlx_main_ctrl.sv
// rtl/dlx_main_ctrl.sv - multi-cycle DLX main control FSM
//
// Sequences fetch/decode/execute/memory/writeback for the DLX subset
// (R-type, J, BEQZ, BNEZ, ADDI, SUBI, LW, SW) and drives the datapath enables.
// Moore outputs are registered from the next state; ir_we and pc_we carry the
// Mealy terms (FETCH completion on mem_ready, branch decision on zero).
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   opcode[5:0]         IR[31:26], valid from DECODE onward
//   zero                regA == 0
//   mem_ready           memory completes the pending access this cycle
//   mem_req/mem_we/iord memory request, write, address select (0=PC, 1=ALUOut)
//   ir_we, pc_we        IR / PC load enables
//   pc_src[1:0]         00=ALU result, 01=ALUOut, 10=jump target
//   alu_srca            0=PC, 1=regA
//   alu_srcb[1:0]       00=regB, 01=4, 10=sext imm, 11=sext imm (branch)
//   ALUOp[2:0]          000=add, 001=sub, 100=R-type
//   reg_we, reg_dst, mem_to_reg  register-file write controls
//   illegal             sticky undefined opcode (or memory timeout)
//   state[3:0]          current state, debug
//
// Optional feature: define DLX_MEM_TIMEOUT_EN to bound memory waits to
// MEM_TIMEOUT cycles; expiry traps.

module dlx_main_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       alu_srca,
  output logic [1:0] alu_srcb,
  output logic [2:0] ALUOp,
  output logic       reg_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_REXEC  = 4'd7,
    S_RWB    = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12,
    S_TRAP   = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQZ  = 6'h04;
  localparam logic [5:0] OP_BNEZ  = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SUBI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  if (MEM_TIMEOUT < 1) begin : g_bad_timeout
    $error("MEM_TIMEOUT must be >= 1");
  end

  state_t state_q;
  state_t nxt;
  logic   jump_pc_we;   // registered unconditional PC load (JUMP)
  logic   mem_timeout;

`ifdef DLX_MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_wait;

  assign mem_wait    = mem_req && !mem_ready;
  assign mem_timeout = mem_wait && (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

  // Any state change clears the counter, so every memory state starts fresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (nxt != state_q) begin
      wait_cnt <= '0;
    end else if (mem_wait) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign mem_timeout = 1'b0;
`endif

  // mem_ready is tested before the timeout so a completing access wins.
  always_comb begin
    nxt = S_RST;
    case (state_q)
      S_RST:    nxt = S_FETCH;
      S_FETCH:  nxt = mem_ready ? S_DECODE : (mem_timeout ? S_TRAP : S_FETCH);
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:         nxt = S_REXEC;
          OP_J:             nxt = S_JUMP;
          OP_BEQZ, OP_BNEZ: nxt = S_BRANCH;
          OP_ADDI, OP_SUBI: nxt = S_IEXEC;
          OP_LW, OP_SW:     nxt = S_MEMADR;
          default:          nxt = S_TRAP;
        endcase
      end
      S_MEMADR: nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  nxt = mem_ready ? S_MEMWB : (mem_timeout ? S_TRAP : S_MEMRD);
      S_MEMWB:  nxt = S_FETCH;
      S_MEMWR:  nxt = mem_ready ? S_FETCH : (mem_timeout ? S_TRAP : S_MEMWR);
      S_REXEC:  nxt = S_RWB;
      S_RWB:    nxt = S_FETCH;
      S_IEXEC:  nxt = S_IWB;
      S_IWB:    nxt = S_FETCH;
      S_BRANCH: nxt = S_FETCH;
      S_JUMP:   nxt = S_FETCH;
      S_TRAP:   nxt = S_TRAP;
      default:  nxt = S_RST;
    endcase
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_RST;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      iord       <= 1'b0;
      jump_pc_we <= 1'b0;
      pc_src     <= 2'b00;
      alu_srca   <= 1'b0;
      alu_srcb   <= 2'b00;
      ALUOp      <= 3'b000;
      reg_we     <= 1'b0;
      reg_dst    <= 1'b0;
      mem_to_reg <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      state_q    <= nxt;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      iord       <= 1'b0;
      jump_pc_we <= 1'b0;
      pc_src     <= 2'b00;
      alu_srca   <= 1'b0;
      alu_srcb   <= 2'b00;
      ALUOp      <= 3'b000;
      reg_we     <= 1'b0;
      reg_dst    <= 1'b0;
      mem_to_reg <= 1'b0;
      illegal    <= 1'b0;
      case (nxt)
        S_FETCH: begin
          mem_req  <= 1'b1;
          alu_srcb <= 2'b01;
        end
        S_DECODE: alu_srcb <= 2'b11;
        S_MEMADR: begin
          alu_srca <= 1'b1;
          alu_srcb <= 2'b10;
        end
        S_MEMRD: begin
          mem_req <= 1'b1;
          iord    <= 1'b1;
        end
        S_MEMWB: begin
          reg_we     <= 1'b1;
          mem_to_reg <= 1'b1;
        end
        S_MEMWR: begin
          mem_req <= 1'b1;
          mem_we  <= 1'b1;
          iord    <= 1'b1;
        end
        S_REXEC: begin
          alu_srca <= 1'b1;
          ALUOp    <= 3'b100;
        end
        S_RWB: begin
          reg_we  <= 1'b1;
          reg_dst <= 1'b1;
        end
        S_IEXEC: begin
          alu_srca <= 1'b1;
          alu_srcb <= 2'b10;
          ALUOp    <= (opcode == OP_SUBI) ? 3'b001 : 3'b000;
        end
        S_IWB:    reg_we <= 1'b1;
        S_BRANCH: pc_src <= 2'b01;
        S_JUMP: begin
          jump_pc_we <= 1'b1;
          pc_src     <= 2'b10;
        end
        S_TRAP:   illegal <= 1'b1;
        default: ;
      endcase
    end
  end

  // Mealy terms: fetch completes in the mem_ready cycle; branch decides on zero.
  assign ir_we = (state_q == S_FETCH) && mem_ready;
  assign pc_we = jump_pc_we
              || ((state_q == S_FETCH) && mem_ready)
              || ((state_q == S_BRANCH) && ((opcode == OP_BEQZ) ? zero : !zero));

  assign state = state_q;

endmodule

// File: tb/tb_dlx_main_ctrl.sv
// tb/tb_dlx_main_ctrl.sv - directed-vector bench for dlx_main_ctrl
module tb_dlx_main_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_we, iord, ir_we, pc_we;
  logic [1:0] pc_src;
  logic       alu_srca;
  logic [1:0] alu_srcb;
  logic [2:0] ALUOp;
  logic       reg_we, reg_dst, mem_to_reg, illegal;
  logic [3:0] state;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dlx_main_ctrl #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we), .pc_we(pc_we),
    .pc_src(pc_src), .alu_srca(alu_srca), .alu_srcb(alu_srcb), .ALUOp(ALUOp),
    .reg_we(reg_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .illegal(illegal), .state(state)
  );

  logic [16:0] outs;
  assign outs = {mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_srca, alu_srcb,
                 ALUOp, reg_we, reg_dst, mem_to_reg, illegal};

  function automatic logic [16:0] ov(input logic mr, mw, io, irw, pcw,
                                     input logic [1:0] ps, input logic sa,
                                     input logic [1:0] sb, input logic [2:0] op,
                                     input logic rw, rd, m2r, ill);
    return {mr, mw, io, irw, pcw, ps, sa, sb, op, rw, rd, m2r, ill};
  endfunction

  logic [16:0] O_ZERO, O_FW, O_FR, O_DEC, O_MADR, O_MRD, O_MWB, O_MWR;
  logic [16:0] O_REX, O_RWB, O_IADD, O_ISUB, O_IWB, O_BT, O_BNT, O_JMP, O_TRAP;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge after inputs are set; samples mid-cycle.
  task automatic step(input string tag, input logic [3:0] es, input logic [16:0] eo);
    #1;
    check({tag, "/state"}, 32'(state), 32'(es));
    check({tag, "/outs"}, 32'(outs), 32'(eo));
  endtask

  // Reset, release at a negedge, check the RST state; next negedge is FETCH.
  task automatic start(input string tag, input logic [5:0] op, input logic rdy, input logic z);
    rst = 1'b1;
    opcode = op;
    mem_ready = rdy;
    zero = z;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    step({tag, "/rst"}, 4'd0, O_ZERO);
  endtask

  task automatic simple(input string tag, input logic [5:0] op, input logic z,
                        input logic [3:0] s3, input logic [16:0] o3,
                        input logic [3:0] s4, input logic [16:0] o4, input logic has4);
    start(tag, op, 1'b1, z);
    @(negedge clk); step({tag, "/f"}, 4'd1, O_FR);
    @(negedge clk); step({tag, "/d"}, 4'd2, O_DEC);
    @(negedge clk); step({tag, "/x"}, s3, o3);
    if (has4) begin
      @(negedge clk); step({tag, "/w"}, s4, o4);
    end
    @(negedge clk); step({tag, "/f2"}, 4'd1, O_FR);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    O_ZERO = '0;
    O_FW   = ov(1,0,0,0,0,2'b00,0,2'b01,3'b000,0,0,0,0);
    O_FR   = ov(1,0,0,1,1,2'b00,0,2'b01,3'b000,0,0,0,0);
    O_DEC  = ov(0,0,0,0,0,2'b00,0,2'b11,3'b000,0,0,0,0);
    O_MADR = ov(0,0,0,0,0,2'b00,1,2'b10,3'b000,0,0,0,0);
    O_MRD  = ov(1,0,1,0,0,2'b00,0,2'b00,3'b000,0,0,0,0);
    O_MWB  = ov(0,0,0,0,0,2'b00,0,2'b00,3'b000,1,0,1,0);
    O_MWR  = ov(1,1,1,0,0,2'b00,0,2'b00,3'b000,0,0,0,0);
    O_REX  = ov(0,0,0,0,0,2'b00,1,2'b00,3'b100,0,0,0,0);
    O_RWB  = ov(0,0,0,0,0,2'b00,0,2'b00,3'b000,1,1,0,0);
    O_IADD = ov(0,0,0,0,0,2'b00,1,2'b10,3'b000,0,0,0,0);
    O_ISUB = ov(0,0,0,0,0,2'b00,1,2'b10,3'b001,0,0,0,0);
    O_IWB  = ov(0,0,0,0,0,2'b00,0,2'b00,3'b000,1,0,0,0);
    O_BT   = ov(0,0,0,0,1,2'b01,0,2'b00,3'b000,0,0,0,0);
    O_BNT  = ov(0,0,0,0,0,2'b01,0,2'b00,3'b000,0,0,0,0);
    O_JMP  = ov(0,0,0,0,1,2'b10,0,2'b00,3'b000,0,0,0,0);
    O_TRAP = ov(0,0,0,0,0,2'b00,0,2'b00,3'b000,0,0,0,1);

    rst = 1'b1; opcode = 6'h00; zero = 1'b0; mem_ready = 1'b0;

    // LW with two FETCH wait cycles: 0,1,1,1,2,3,4,5,1
    start("lw", 6'h23, 1'b0, 1'b0);
    @(negedge clk); step("lw/fw1", 4'd1, O_FW);
    @(negedge clk); step("lw/fw2", 4'd1, O_FW);
    @(negedge clk); mem_ready = 1'b1; step("lw/fr", 4'd1, O_FR);
    @(negedge clk); step("lw/dec", 4'd2, O_DEC);
    @(negedge clk); step("lw/madr", 4'd3, O_MADR);
    @(negedge clk); step("lw/mrd", 4'd4, O_MRD);
    @(negedge clk); step("lw/mwb", 4'd5, O_MWB);
    @(negedge clk); step("lw/f2", 4'd1, O_FR);

    simple("rtype", 6'h00, 1'b0, 4'd7, O_REX, 4'd8, O_RWB, 1'b1);
    simple("beqz_t", 6'h04, 1'b1, 4'd11, O_BT, 4'd0, O_ZERO, 1'b0);
    simple("beqz_n", 6'h04, 1'b0, 4'd11, O_BNT, 4'd0, O_ZERO, 1'b0);
    simple("bnez_t", 6'h05, 1'b0, 4'd11, O_BT, 4'd0, O_ZERO, 1'b0);
    simple("bnez_n", 6'h05, 1'b1, 4'd11, O_BNT, 4'd0, O_ZERO, 1'b0);
    simple("addi", 6'h08, 1'b0, 4'd9, O_IADD, 4'd10, O_IWB, 1'b1);
    simple("subi", 6'h0A, 1'b0, 4'd9, O_ISUB, 4'd10, O_IWB, 1'b1);
    simple("sw", 6'h2B, 1'b0, 4'd3, O_MADR, 4'd6, O_MWR, 1'b1);
    simple("jump", 6'h02, 1'b0, 4'd12, O_JMP, 4'd0, O_ZERO, 1'b0);

    // Undefined opcode traps and stays there until reset
    start("trap", 6'h3F, 1'b1, 1'b0);
    @(negedge clk); step("trap/f", 4'd1, O_FR);
    @(negedge clk); step("trap/d", 4'd2, O_DEC);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); step("trap/hold", 4'd15, O_TRAP);
    end
    rst = 1'b1;
    step("trap/rst", 4'd0, O_ZERO);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); step("trap/refetch", 4'd1, O_FR);

    // Reset mid-cycle during a MEMRD wait drops everything before the next edge
    start("abort", 6'h23, 1'b1, 1'b0);
    @(negedge clk); step("abort/f", 4'd1, O_FR);
    @(negedge clk); step("abort/d", 4'd2, O_DEC);
    @(negedge clk); mem_ready = 1'b0; step("abort/madr", 4'd3, O_MADR);
    @(negedge clk); step("abort/mrd1", 4'd4, O_MRD);
    @(negedge clk); step("abort/mrd2", 4'd4, O_MRD);
    @(posedge clk); #2; rst = 1'b1;
    step("abort/async", 4'd0, O_ZERO);
    @(negedge clk); rst = 1'b0;

    // Long MEMRD wait: traps after 16 waits only when the timeout is built in
    start("tmo", 6'h23, 1'b1, 1'b0);
    @(negedge clk); step("tmo/f", 4'd1, O_FR);
    @(negedge clk); step("tmo/d", 4'd2, O_DEC);
    @(negedge clk); mem_ready = 1'b0; step("tmo/madr", 4'd3, O_MADR);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); step("tmo/wait", 4'd4, O_MRD);
    end
`ifdef DLX_MEM_TIMEOUT_EN
    @(negedge clk); step("tmo/trap", 4'd15, O_TRAP);
`else
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); step("tmo/nolimit", 4'd4, O_MRD);
    end
    mem_ready = 1'b1;
    @(negedge clk); step("tmo/mwb", 4'd5, O_MWB);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
